aes_inv_sub_bytes: RTL and testbench

//  Iterative AES InvSubBytes engine for the decryption datapath. Takes a 128-bit

---
 rtl/aes_inv_sub_bytes.sv | 172 +++++++++++++++++
 tb/tb_aes_inv_sub_bytes.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/aes_inv_sub_bytes.sv
// aes_inv_sub_bytes: iterative AES InvSubBytes engine, LANES bytes per cycle over valid/ready.
// Define AES_INV_SUB_SELFCHECK_EN to add a forward S-box round-trip check driving sticky chk_err.
module aes_inv_sub_bytes #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
`ifdef AES_INV_SUB_SELFCHECK_EN
  ,
  output logic         chk_err
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t       state_q, state_d;
  logic [127:0] work_q, work_d;
  logic [3:0]   ptr_q, ptr_d;
  logic [4:0]   ptr_nxt;
  logic [3:0]   lane_idx [LANES];
  logic [7:0]   lane_in  [LANES];
  logic [7:0]   lane_out [LANES];

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    case (x)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
    endcase
    return r;
  endfunction

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
  end

  // ptr is always a multiple of LANES, so lane slices never straddle the state
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_idx[i] = ptr_q + 4'(i);
    assign lane_in[i]  = work_q[{lane_idx[i], 3'b000} +: 8];
    assign lane_out[i] = inv_sbox(lane_in[i]);
  end

  assign ptr_nxt   = {1'b0, ptr_q} + 5'(LANES);
  assign in_ready  = rst_n && state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_state = work_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      work_d  = in_state;
      ptr_d   = '0;
    end else if (state_q == RUN) begin
      for (int k = 0; k < LANES; k++) work_d[{lane_idx[k], 3'b000} +: 8] = lane_out[k];
      ptr_d   = ptr_nxt[3:0];
      state_d = ptr_nxt[4] ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef AES_INV_SUB_SELFCHECK_EN
  logic             chk_err_q, chk_err_d;
  logic [LANES-1:0] lane_mis;

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    case (x)
      8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5;
      8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
      8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0;
      8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
      8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc;
      8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
      8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a;
      8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
      8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0;
      8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
      8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b;
      8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
      8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85;
      8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
      8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5;
      8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
      8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17;
      8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
      8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88;
      8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
      8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c;
      8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
      8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9;
      8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
      8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6;
      8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
      8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e;
      8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
      8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94;
      8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
      8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68;
      8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
    endcase
    return r;
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_chk
    assign lane_mis[i] = fwd_sbox(lane_out[i]) != lane_in[i];
  end

  always_comb chk_err_d = chk_err_q || (state_q == RUN && |lane_mis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else        chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`endif
endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// tb_aes_inv_sub_bytes: vector table plus backpressure and mid-RUN reset sequences,
// with expected results derived from a GF(2^8) model of the AES S-box.
module tb_aes_inv_sub_bytes;
  localparam int LANES = 4;
  localparam int LAT   = 16 / LANES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [127:0] in_state = '0;
  logic [127:0] out_state;
`ifdef AES_INV_SUB_SELFCHECK_EN
  logic         chk_err;
`endif

  aes_inv_sub_bytes #(.LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
`ifdef AES_INV_SUB_SELFCHECK_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] st;
    logic [127:0] ex;
  } vec_t;

  vec_t         vecs [18];
  logic [7:0]   inv_m [256];
  logic [127:0] exp_q [$];
  logic [127:0] snap;
  int           total = 0;
  int           passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Scoreboard: an output is consumed at the edge following a negedge with valid&ready
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL spurious_output: got %h expected no output", out_state);
      end else chk("out_state", out_state, exp_q.pop_front());
    end

  task automatic send(input logic [127:0] st, input logic [127:0] ex);
    int n;
    in_state = st;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_accept", in_ready, 1);
    exp_q.push_back(ex);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", n, LAT);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("drained", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) inv_m[sbox_calc(8'(i))] = 8'(i);
    vecs[0].st = {16{8'h63}};
    vecs[0].ex = 128'h0;
    vecs[1].st = 128'h76abd7fe2b670130c56f6bf27b777c63;
    vecs[1].ex = 128'h0f0e0d0c0b0a09080706050403020100;
    for (int t = 0; t < 16; t++)
      for (int k = 0; k < 16; k++) begin
        vecs[t + 2].st[8*k +: 8] = 8'(16 * t + k);
        vecs[t + 2].ex[8*k +: 8] = inv_m[16 * t + k];
      end

    #3;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_state", out_state, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    for (int i = 0; i < 18; i++) begin
      send(vecs[i].st, vecs[i].ex);
      drain();
    end

    out_ready = 1'b0;
    send(vecs[5].st, vecs[5].ex);
    snap = out_state;
    in_state = vecs[6].st;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_out_state_stable", out_state, snap);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid_held", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_late_accept", busy, 0);

    in_state = vecs[7].st;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("run_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_out_state", out_state, 0);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_out_state", out_state, 0);
    send(vecs[1].st, vecs[1].ex);
    drain();

`ifdef AES_INV_SUB_SELFCHECK_EN
    chk("chk_err_clear", chk_err, 0);
`endif
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
